// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces whole scans, reports last key press.
// Latency: key_word updates on the final sample of the accepting scan, at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV+2 cycles after a clean press.
// Backpressure: none; the reader clears pending/overrun with a one-cycle rd_ack, and a coincident press wins.
//
// Ports:
//   data_clk  clock, all state on posedge
//   rst       asynchronous active-high reset
//   col_in    keypad columns, active-low, asynchronous to data_clk
//   rd_ack    one-cycle pulse, clears pending and overrun
//   row_out   active-low row drive, exactly one bit low
//   key_word  {pending, overrun, 25'b0, held, code[3:0]}
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        data_clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  input  logic        rd_ack,
  output logic [3:0]  row_out,
  output logic [31:0] key_word
);

  localparam int             SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB        = 4'(DEBOUNCE_SCANS);

  // Scan result encoding: {kind[1:0], code[3:0]}; code is zero unless SINGLE.
  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  logic [3:0]       col_meta_q, col_sync_q;
  logic [SW-1:0]    slot_q, slot_d;
  logic [1:0]       row_q, row_d;
  logic [2:0][3:0]  samp_q, samp_d;    // column samples for rows 0..2 of the current scan
  logic [5:0]       prev_q, prev_d;
  logic [5:0]       deb_q, deb_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             held_q, held_d;
  logic [3:0]       code_q, code_d;

  logic             slot_last, scan_done;
  logic [15:0]      down;
  logic [4:0]       n_down;
  logic [3:0]       one_idx;
  logic [5:0]       res;
  logic             accept;

  assign slot_last = (slot_q == SLOT_LAST);
  assign scan_done = slot_last && (row_q == 2'd3);

  // Row 3 is never stored: its sample is consumed directly in the same cycle.
  assign down = ~{col_sync_q, samp_q};

  always_comb begin
    n_down  = '0;
    one_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (down[i]) begin
        n_down  = n_down + 5'd1;
        one_idx = 4'(i);
      end
    end
  end

  always_comb begin
    if (n_down == 5'd0)      res = {RES_NONE, 4'd0};
    else if (n_down == 5'd1) res = {RES_SINGLE, one_idx};
    else                     res = {RES_MULTI, 4'd0};
  end

  always_comb begin
    slot_d    = slot_last ? '0 : slot_q + SW'(1);
    row_d     = slot_last ? row_q + 2'd1 : row_q;
    samp_d    = samp_q;
    prev_d    = prev_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    pending_d = pending_q & ~rd_ack;
    overrun_d = overrun_q & ~rd_ack;
    held_d    = held_q;
    code_d    = code_q;

    for (int r = 0; r < 3; r++) begin
      if (slot_last && row_q == 2'(r)) samp_d[r] = col_sync_q;
    end

    if (scan_done) begin
      prev_d = res;
      if (res == prev_q) cnt_d = (cnt_q == DB) ? cnt_q : cnt_q + 4'd1;
      else               cnt_d = 4'd1;
      // Acceptance only on the scan that brings the count up to the threshold.
      accept = (cnt_d == DB) && (res != deb_q);
      if (accept) deb_d = res;
    end

    if (accept) begin
      if (res[5:4] == RES_SINGLE) begin
        code_d    = res[3:0];
        held_d    = 1'b1;
        pending_d = 1'b1;
        overrun_d = pending_q & ~rd_ack;
      end else begin
        // NONE releases; MULTI is treated as ghosting and produces no event.
        held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      slot_q     <= '0;
      row_q      <= 2'd0;
      samp_q     <= {3{4'hF}};
      prev_q     <= {RES_NONE, 4'd0};
      deb_q      <= {RES_NONE, 4'd0};
      cnt_q      <= 4'd0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      held_q     <= 1'b0;
      code_q     <= 4'd0;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
      slot_q     <= slot_d;
      row_q      <= row_d;
      samp_q     <= samp_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      held_q     <= held_d;
      code_q     <= code_d;
    end
  end

  assign row_out  = ~(4'b0001 << row_q);
  assign key_word = {pending_q, overrun_q, 25'd0, held_q, code_q};

endmodule
